// File: rtl/pc_gen_if.sv
// Control/status bundle between decode/execute and the next-PC generator.
// The master drives PC-selection controls; the slave (pc_gen) returns PC state.
interface pc_gen_if #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned IMM_BITS  = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

    logic                en;
    logic [2:0]          pc_mode;
    logic [XLEN-1:0]     pc_new;
    logic [IMM_BITS-1:0] imm;
    logic [XLEN-1:0]     reg_val;
    logic                ras_push;
    logic                trap;
    logic [XLEN-1:0]     trap_vec;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pc_prev;
    logic                misalign;
    logic [XLEN-1:0]     bad_target;
    logic [CntW-1:0]     ras_count;

    modport master (
        output en, pc_mode, pc_new, imm, reg_val, ras_push, trap, trap_vec,
        input  pc, pc_prev, misalign, bad_target, ras_count
    );

    modport slave (
        input  en, pc_mode, pc_new, imm, reg_val, ras_push, trap, trap_vec,
        output pc, pc_prev, misalign, bad_target, ras_count
    );
endinterface

// File: rtl/pc_gen.sv
// Next-PC generator and PC register for fetch, with trap redirect, misalignment
// detection and a circular return-address stack for call/return prediction.
module pc_gen #(
    parameter int unsigned    XLEN         = 64,
    parameter int unsigned    IMM_BITS     = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned    RAS_DEPTH    = 4
) (
    input logic     clk,
    input logic     rst_n,
    pc_gen_if.slave bus
);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [2:0] PcAdd4 = 3'd0;
    localparam logic [2:0] PcImm  = 3'd1;
    localparam logic [2:0] PcReg  = 3'd2;
    localparam logic [2:0] PcRas  = 3'd3;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_prev_q, pc_prev_d;
    logic [XLEN-1:0] bad_target_q, bad_target_d;
    logic            misalign_q, misalign_d;
    logic [PtrW-1:0] top_q, top_d;
    logic [CntW-1:0] count_q, count_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];

    logic [XLEN-1:0] sext_imm, reg_tgt, target, link;
    logic            ras_valid, pop, push, ras_we;
    logic [PtrW-1:0] ras_waddr;

    assign sext_imm  = XLEN'($signed(bus.imm));
    assign reg_tgt   = (bus.reg_val + sext_imm) & ~XLEN'(1);
    assign link      = pc_q + XLEN'(4);
    assign ras_valid = (count_q != '0);
    assign pop       = (bus.pc_mode == PcRas) && ras_valid;
    assign push      = bus.ras_push;

    always_comb begin
        target = pc_q;
        case (bus.pc_mode)
            PcAdd4:  target = pc_q + XLEN'(4);
            PcImm:   target = bus.pc_new + sext_imm;
            PcReg:   target = reg_tgt;
            PcRas:   target = ras_valid ? ras_q[top_q] : reg_tgt;
            default: target = pc_q;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        pc_prev_d    = pc_prev_q;
        bad_target_d = bad_target_q;
        misalign_d   = 1'b0;
        top_d        = top_q;
        count_d      = count_q;
        ras_we       = 1'b0;
        ras_waddr    = top_q;
        if (bus.trap) begin
            pc_d      = bus.trap_vec & ~XLEN'(3);
            pc_prev_d = pc_q;
        end else if (bus.en) begin
            if (target[1:0] != 2'b00) begin
                misalign_d   = 1'b1;
                bad_target_d = target;
            end else begin
                pc_d      = target;
                pc_prev_d = pc_q;
            end
            // RAS follows the control flow even when the target is rejected
            if (push && pop) begin
                ras_we = 1'b1;
            end else if (push) begin
                ras_we    = 1'b1;
                ras_waddr = top_q + PtrW'(1);
                top_d     = top_q + PtrW'(1);
                if (count_q != CntW'(RAS_DEPTH)) count_d = count_q + CntW'(1);
            end else if (pop) begin
                top_d   = top_q - PtrW'(1);
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_VECTOR;
            pc_prev_q    <= RESET_VECTOR;
            bad_target_q <= '0;
            misalign_q   <= 1'b0;
            top_q        <= '0;
            count_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            pc_prev_q    <= pc_prev_d;
            bad_target_q <= bad_target_d;
            misalign_q   <= misalign_d;
            top_q        <= top_d;
            count_q      <= count_d;
        end
    end

    // Entries carry no reset; only counted-valid entries are ever read
    always_ff @(posedge clk) begin
        if (rst_n && ras_we) ras_q[ras_waddr] <= link;
    end

    assign bus.pc         = pc_q;
    assign bus.pc_prev    = pc_prev_q;
    assign bus.misalign   = misalign_q;
    assign bus.bad_target = bad_target_q;
    assign bus.ras_count  = count_q;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential flow, redirects, misalignment, RAS, trap, reset.
module tb_pc_gen;
    localparam int unsigned XLEN = 64;
    localparam int unsigned IMM_BITS = 32;
    localparam int unsigned RAS_DEPTH = 4;
    localparam logic [63:0] RV = 64'h1000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_bad = 0;

    pc_gen_if #(.XLEN(XLEN), .IMM_BITS(IMM_BITS), .RAS_DEPTH(RAS_DEPTH)) bus ();

    pc_gen #(
        .XLEN        (XLEN),
        .IMM_BITS    (IMM_BITS),
        .RESET_VECTOR(RV),
        .RAS_DEPTH   (RAS_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [2:0] mode, input logic push,
                         input logic trap);
        bus.en       = en;
        bus.pc_mode  = mode;
        bus.ras_push = push;
        bus.trap     = trap;
    endtask

    task automatic trap_to(input logic [63:0] vec);
        drive(1'b0, 3'd2, 1'b0, 1'b1);
        bus.trap_vec = vec;
        step();
        bus.trap = 1'b0;
    endtask

    logic [63:0] pops [4];

    initial begin
        pops[0] = 64'h114; pops[1] = 64'h110; pops[2] = 64'h10C; pops[3] = 64'h108;
        rst_n = 1'b0;
        bus.pc_new = '0; bus.imm = '0; bus.reg_val = '0; bus.trap_vec = 64'h7777;
        drive(1'b1, 3'd0, 1'b1, 1'b1);
        #2;
        step(); step();
        chk("rst_pc", bus.pc, RV);
        chk("rst_prev", bus.pc_prev, RV);
        chk("rst_mis", 64'(bus.misalign), 64'd0);
        chk("rst_bad", bus.bad_target, 64'd0);
        chk("rst_cnt", 64'(bus.ras_count), 64'd0);

        rst_n = 1'b1;
        drive(1'b1, 3'd0, 1'b0, 1'b0);
        step(); chk("pc4_1", bus.pc, 64'h1004);
        step(); chk("pc4_2", bus.pc, 64'h1008);
        step(); chk("pc4_3", bus.pc, 64'h100C);
        chk("pc4_prev", bus.pc_prev, 64'h1008);

        bus.pc_new = 64'h2000; bus.imm = 32'hFFFF_FFF0; bus.pc_mode = 3'd1;
        step(); chk("imm_neg", bus.pc, 64'h1FF0);
        chk("imm_prev", bus.pc_prev, 64'h100C);

        bus.reg_val = 64'h3001; bus.imm = 32'd4; bus.pc_mode = 3'd2;
        step(); chk("jalr_b0", bus.pc, 64'h3004);

        bus.reg_val = 64'h3002; bus.imm = 32'd0;
        step();
        chk("mis_pulse", 64'(bus.misalign), 64'd1);
        chk("mis_bad", bus.bad_target, 64'h3002);
        chk("mis_hold", bus.pc, 64'h3004);
        bus.pc_mode = 3'd5;
        step();
        chk("mis_clr", 64'(bus.misalign), 64'd0);
        chk("bad_keep", bus.bad_target, 64'h3002);
        chk("hold_pc", bus.pc, 64'h3004);
        chk("hold_prev", bus.pc_prev, 64'h3004);

        trap_to(64'h100);
        chk("trap100", bus.pc, 64'h100);
        chk("trap100_prev", bus.pc_prev, 64'h3004);

        drive(1'b1, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk("push5_pc", bus.pc, 64'h114);
        chk("push5_cnt", 64'(bus.ras_count), 64'd4);

        drive(1'b1, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("pop%0d", i), bus.pc, pops[i]);
            chk($sformatf("pop%0d_cnt", i), 64'(bus.ras_count), 64'(3 - i));
        end
        bus.reg_val = 64'h4000; bus.imm = 32'd8;
        step();
        chk("pop_empty", bus.pc, 64'h4008);
        chk("pop_empty_cnt", 64'(bus.ras_count), 64'd0);

        trap_to(64'h4FC);
        drive(1'b1, 3'd0, 1'b1, 1'b0);
        step();
        chk("pre_pp_pc", bus.pc, 64'h500);
        trap_to(64'h800);
        drive(1'b1, 3'd3, 1'b1, 1'b0);
        step();
        chk("pp_pc", bus.pc, 64'h500);
        chk("pp_cnt", 64'(bus.ras_count), 64'd1);
        drive(1'b1, 3'd3, 1'b0, 1'b0);
        step();
        chk("pp_top", bus.pc, 64'h804);
        chk("pp_top_cnt", 64'(bus.ras_count), 64'd0);

        drive(1'b1, 3'd0, 1'b1, 1'b0);
        step();
        chk("pre_trap_cnt", 64'(bus.ras_count), 64'd1);
        bus.reg_val = 64'h3002; bus.imm = 32'd0;
        trap_to(64'h8003);
        chk("trap_pc", bus.pc, 64'h8000);
        chk("trap_prev", bus.pc_prev, 64'h808);
        chk("trap_cnt", 64'(bus.ras_count), 64'd1);
        chk("trap_mis", 64'(bus.misalign), 64'd0);
        drive(1'b1, 3'd3, 1'b0, 1'b0);
        step();
        chk("trap_ras", bus.pc, 64'h808);

        drive(1'b0, 3'd0, 1'b1, 1'b0);
        step(); step();
        chk("stall_pc", bus.pc, 64'h808);
        chk("stall_prev", bus.pc_prev, 64'h8000);
        chk("stall_cnt", 64'(bus.ras_count), 64'd0);

        drive(1'b1, 3'd0, 1'b1, 1'b0);
        step();
        chk("pre_rst_cnt", 64'(bus.ras_count), 64'd1);
        rst_n = 1'b0;
        drive(1'b1, 3'd0, 1'b1, 1'b1);
        bus.trap_vec = 64'h9000;
        step();
        chk("rst2_pc", bus.pc, RV);
        chk("rst2_prev", bus.pc_prev, RV);
        chk("rst2_cnt", 64'(bus.ras_count), 64'd0);
        chk("rst2_bad", bus.bad_target, 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-PC generator and PC register for the fetch stage; successor to the single-width PC writeback unit.
- Adds the following over that unit:
  - configurable XLEN and immediate width
  - reset vector
  - trap redirect
  - JALR bit-0 clearing
  - instruction-misalignment detection
  - a circular return-address stack (RAS) for call/return prediction
- Feeds the fetch address; driven by decode/execute control.

Parameters:
XLEN, 64, width of PC and all address operands
IMM_BITS, 32, width of incoming immediate; sign-extended to XLEN (IMM_BITS <= XLEN)
RESET_VECTOR, 0, PC value after reset
RAS_DEPTH, 4, RAS entries; power of two, >= 2

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  reset, synchronous, active-low
en  in  1  PC update enable (stall when 0)
pc_mode  in  3  0=PC_4, 1=PC_IMM, 2=PC_REG, 3=PC_RAS, 4..7=PC_HOLD
pc_new  in  XLEN  base for PC_IMM (branch/JAL instruction PC)
imm  in  IMM_BITS  offset, sign-extended
reg_val  in  XLEN  rs1 value for PC_REG and RAS fallback
ras_push  in  1  push link address (pc+4) onto RAS
trap  in  1  redirect to trap_vec
trap_vec  in  XLEN  trap handler address
pc  out  XLEN  current PC (registered)
pc_prev  out  XLEN  PC value before last successful update
misalign  out  1  one-cycle pulse: computed target misaligned, update suppressed
bad_target  out  XLEN  last misaligned target (holds until next misalign or reset)
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

Behaviour:
- Reset: clk edge with rst_n=0 overrides everything.
  - pc=pc_prev=RESET_VECTOR
  - misalign=0, bad_target=0, ras_count=0, RAS top pointer=0
- Priority per cycle: reset > trap > en.
- Target (combinational, XLEN-bit wrap-around add, carry discarded):
  - PC_4: pc+4
  - PC_IMM: pc_new+sext(imm)
  - PC_REG: (reg_val+sext(imm)) with bit 0 cleared
  - PC_RAS, ras_count>0: RAS top entry
  - PC_RAS, ras_count==0: PC_REG computation (fallback)
  - PC_HOLD: pc
- Trap: trap=1 loads pc=trap_vec with bits[1:0] forced 0 and pc_prev=pc, regardless of en/pc_mode.
  - RAS untouched; misalign=0 that cycle.
- en=1, trap=0: if target[1:0]!=0, pc holds, misalign=1 for that cycle only, bad_target=target.
  - RAS still updated per rules below.
  - Otherwise pc=target, pc_prev=old pc (PC_HOLD also copies pc_prev=pc).
- en=0, trap=0: pc, pc_prev and RAS hold; misalign=0; ras_push/pc_mode ignored.
- Latency: target visible on pc one cycle after the enabling edge; no bypass.
- RAS (only when en=1, trap=0); link = old pc+4:
  - Push only: write link at top+1, top advances modulo RAS_DEPTH; ras_count saturates at RAS_DEPTH, oldest entry silently overwritten.
  - Pop only (PC_RAS, count>0): top retreats modulo RAS_DEPTH; count decrements.
  - Pop on empty: no pointer/count change.
  - Push and pop same cycle (PC_RAS, count>0): target = old top; top entry overwritten with link; pointer and count unchanged.
  - Push with PC_RAS on empty RAS: fallback target used, push proceeds normally (count=1).
- RAS entries are not reset (only pointer/count); an entry is never read unless counted valid.

Test Plan:
- Reset, RESET_VECTOR=0x1000, then en=1, PC_4 for 3 cycles -> pc=0x1004,0x1008,0x100C; pc_prev=0x1008 after third edge.
- pc_new=0x2000, imm=0xFFFFFFF0, PC_IMM -> pc=0x1FF0. Then reg_val=0x3001, imm=4, PC_REG -> pc=0x3004 (bit 0 cleared). Then reg_val=0x3002, imm=0, PC_REG -> misalign=1 for one cycle, bad_target=0x3002, pc stays 0x3004.
- RAS_DEPTH=4, pc=0x100: 5 pushes via PC_4 -> ras_count=4. Then 4 PC_RAS pops return 0x114,0x110,0x10C,0x108, count reaches 0. Fifth pop falls back to reg_val+imm.
- Push and pop same cycle with top=0x500, pc=0x800 -> pc=0x500, top becomes 0x804, count unchanged.
- trap=1, trap_vec=0x8003 while en=0 and PC_REG -> pc=0x8000, RAS and count unchanged, misalign=0.
- en=0 with ras_push=1 and PC_4 -> pc, pc_prev, ras_count all hold. rst_n=0 mid-sequence with trap=1 -> pc=RESET_VECTOR, ras_count=0, bad_target=0.
